// File: rtl/fifo_stream_pkg.sv
// Shared types and constants for the FIFO-to-stream reader.
package fifo_stream_pkg;

  // Number of words the output buffer can hold.
  localparam int unsigned BUF_DEPTH = 2;

  // Buffer occupancy; the encoding equals the number of buffered words.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/fifo_stream_skid.sv
// Two-entry in-order buffer. The head register drives the stream data
// directly, so the output is always registered.
module fifo_stream_skid
  import fifo_stream_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [BITS-1:0] push_data,
  input  logic            pop,
  output logic [BITS-1:0] data,
  output logic [1:0]      count,
  output logic            valid
);

  occ_e            state_q, state_d;
  logic [BITS-1:0] head_q, head_d;
  logic [BITS-1:0] tail_q, tail_d;

  // Next occupancy and entry contents from push/pop; head is always the oldest word.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = push_data;
          state_d = ONE;
        end
      end
      ONE: begin
        unique case ({push, pop})
          2'b10: begin
            tail_d  = push_data;
            state_d = TWO;
          end
          2'b01:   state_d = EMPTY;
          2'b11:   head_d  = push_data;
          default: ;
        endcase
      end
      TWO: begin
        // The issuer never pushes into a full buffer unless a pop frees a slot.
        if (pop) begin
          head_d = tail_q;
          if (push) tail_d = push_data;
          else      state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Occupancy and entry registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled at the same edge.
    if (rst) begin
      state_q <= EMPTY;
      // NOTE: both entries are cleared, not just the occupancy, because the
      // head register is the visible stream data and must read 0 in reset.
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign data  = head_q;
  assign count = state_q;
  assign valid = (state_q != EMPTY);

endmodule

// File: rtl/fifo_stream_reader.sv
// Reads words from a FIFO with one-cycle read latency and presents them as a
// valid/ready stream. Pops are issued only when the two-entry buffer is sure
// to have room when the word arrives, so nothing is dropped.
// Optional feature: define FIFO_STREAM_READER_COUNT_EN to add p_pop_count,
// a wrapping count of stream transfers.
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic            read_clk,
  input  logic            read_rst,
  output logic            p_read_en,
  input  logic [BITS-1:0] p_read_data,
  input  logic            p_read_empty,
  output logic            p_out_valid,
  output logic [BITS-1:0] p_out_data,
  input  logic            p_out_ready
`ifdef FIFO_STREAM_READER_COUNT_EN
  ,
  output logic [31:0]     p_pop_count
`endif
);

  logic       in_flight_q, in_flight_d;
  logic       transfer;
  logic [1:0] buf_count;
  logic [2:0] occ_after;

  assign transfer = p_out_valid && p_out_ready;

  // Words committed to the buffer once this edge completes: buffered plus the
  // one arriving now, minus the one leaving. A new pop is safe only below depth.
  assign occ_after = {1'b0, buf_count} + {2'b00, in_flight_q} - {2'b00, transfer};

  assign p_read_en   = !read_rst && !p_read_empty && (occ_after < 3'(BUF_DEPTH));
  assign in_flight_d = p_read_en;

  // Remember an accepted pop so its data is captured one cycle later.
  always_ff @(posedge read_clk) begin
    if (read_rst) in_flight_q <= 1'b0;
    else          in_flight_q <= in_flight_d;
  end

  fifo_stream_skid #(
    .BITS (BITS)
  ) u_skid (
    .clk       (read_clk),
    .rst       (read_rst),
    .push      (in_flight_q),
    .push_data (p_read_data),
    .pop       (transfer),
    .data      (p_out_data),
    .count     (buf_count),
    .valid     (p_out_valid)
  );

`ifdef FIFO_STREAM_READER_COUNT_EN
  logic [31:0] pop_count_q, pop_count_d;

  assign pop_count_d = transfer ? pop_count_q + 32'd1 : pop_count_q;

  // Transfer counter; wraps naturally at 32 bits.
  always_ff @(posedge read_clk) begin
    if (read_rst) pop_count_q <= '0;
    else          pop_count_q <= pop_count_d;
  end

  assign p_pop_count = pop_count_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader. A behavioural FIFO supplies
// words one cycle after each accepted pop; every accepted pop pushes its word
// onto a scoreboard queue that is popped on each stream transfer.
module tb_fifo_stream_reader;

  localparam int BITS = 32;

  logic            read_clk = 1'b0;
  logic            read_rst = 1'b1;
  logic            p_read_en;
  logic [BITS-1:0] p_read_data = '0;
  logic            p_read_empty = 1'b1;
  logic            p_out_valid;
  logic [BITS-1:0] p_out_data;
  logic            p_out_ready = 1'b0;
`ifdef FIFO_STREAM_READER_COUNT_EN
  logic [31:0]     p_pop_count;
`endif

  always #5 read_clk = ~read_clk;

  fifo_stream_reader #(
    .BITS (BITS)
  ) dut (
    .read_clk     (read_clk),
    .read_rst     (read_rst),
    .p_read_en    (p_read_en),
    .p_read_data  (p_read_data),
    .p_read_empty (p_read_empty),
    .p_out_valid  (p_out_valid),
    .p_out_data   (p_out_data),
    .p_out_ready  (p_out_ready)
`ifdef FIFO_STREAM_READER_COUNT_EN
    ,
    .p_pop_count  (p_pop_count)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;
  int n_xfer  = 0;

  logic [BITS-1:0] src_q[$];
  logic [BITS-1:0] exp_q[$];

  bit              last_en, last_valid, last_pop, last_xfer;
  logic [BITS-1:0] last_data;

  // One clock cycle: drive flags, sample outputs before the edge, model the FIFO.
  task automatic step(input bit empty_req, input bit ready);
    logic [BITS-1:0] w;
    logic [BITS-1:0] w_exp;
    bit              pop_acc;
    w = '0;
    @(negedge read_clk);
    p_read_empty = empty_req || (src_q.size() == 0);
    p_out_ready  = ready;
    #1;
    last_en    = (p_read_en === 1'b1);
    last_valid = (p_out_valid === 1'b1);
    last_data  = p_out_data;
    if (p_read_empty) begin
      n_total++;
      if (p_read_en !== 1'b0)
        $display("FAIL en_while_empty: p_read_en=%b required 0", p_read_en);
      else n_pass++;
    end
    pop_acc   = last_en && !p_read_empty;
    last_pop  = pop_acc;
    last_xfer = last_valid && ready;
    if (last_xfer) begin
      n_total++;
      n_xfer++;
      if (exp_q.size() == 0) begin
        $display("FAIL spurious_word: got %h required no transfer", p_out_data);
      end else begin
        w_exp = exp_q.pop_front();
        if (p_out_data !== w_exp)
          $display("FAIL stream_data: got %h required %h", p_out_data, w_exp);
        else n_pass++;
      end
    end
    if (pop_acc) begin
      w = src_q.pop_front();
      exp_q.push_back(w);
    end
    @(posedge read_clk);
    #1;
    p_read_data = pop_acc ? w : $urandom();
  endtask

  // Assert reset for two edges, checking outputs are idle throughout.
  task automatic apply_reset();
    @(negedge read_clk);
    read_rst     = 1'b1;
    p_read_empty = 1'b0;
    p_out_ready  = 1'b1;
    #1;
    n_total++;
    if (p_read_en !== 1'b0) $display("FAIL rst_read_en_same_cycle: got %b required 0", p_read_en);
    else n_pass++;
    repeat (2) begin
      @(posedge read_clk);
      #1;
      n_total++;
      if (p_out_valid !== 1'b0) $display("FAIL rst_valid: got %b required 0", p_out_valid);
      else n_pass++;
      n_total++;
      if (p_out_data !== '0) $display("FAIL rst_data: got %h required 0", p_out_data);
      else n_pass++;
      n_total++;
      if (p_read_en !== 1'b0) $display("FAIL rst_read_en: got %b required 0", p_read_en);
      else n_pass++;
    end
    read_rst = 1'b0;
    src_q.delete();
    exp_q.delete();
    p_read_data = $urandom();
    n_xfer = 0;
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_basic();
    logic [BITS-1:0] tbl[3];
    bit en_exp, val_exp;
    tbl = '{32'h11, 32'h22, 32'h33};
    apply_reset();
    for (int i = 0; i < 3; i++) src_q.push_back(tbl[i]);
    for (int c = 0; c < 7; c++) begin
      step(1'b0, 1'b1);
      en_exp  = (c <= 2);
      val_exp = (c >= 2) && (c <= 4);
      n_total++;
      if (last_en !== en_exp) $display("FAIL basic_read_en c%0d: got %b required %b", c, last_en, en_exp);
      else n_pass++;
      n_total++;
      if (last_valid !== val_exp) $display("FAIL basic_valid c%0d: got %b required %b", c, last_valid, val_exp);
      else n_pass++;
      if (val_exp) begin
        n_total++;
        if (last_data !== tbl[c-2]) $display("FAIL basic_data c%0d: got %h required %h", c, last_data, tbl[c-2]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [BITS-1:0] tbl[5];
    int pops;
    tbl = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
    apply_reset();
    for (int i = 0; i < 5; i++) src_q.push_back(tbl[i]);
    pops = 0;
    repeat (6) begin
      step(1'b0, 1'b0);
      if (last_pop) pops++;
    end
    n_total++;
    if (pops != 2) $display("FAIL bp_pop_count: got %0d required 2", pops);
    else n_pass++;
    n_total++;
    if (!last_valid || last_data !== 32'h11)
      $display("FAIL bp_hold: valid=%b data=%h required valid=1 data=00000011", last_valid, last_data);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1);
      n_total++;
      if (!last_xfer || last_data !== tbl[i])
        $display("FAIL bp_drain %0d: xfer=%b data=%h required xfer=1 data=%h", i, last_xfer, last_data, tbl[i]);
      else n_pass++;
    end
    repeat (4) step(1'b1, 1'b1);
    n_total++;
    if (exp_q.size() != 0) $display("FAIL bp_leftover: got %0d words required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_empty();
    apply_reset();
    repeat (20) begin
      step(1'b1, 1'b1);
      n_total++;
      if (last_valid !== 1'b0) $display("FAIL empty_valid: got %b required 0", last_valid);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 10000; i++) begin
      if (src_q.size() < 4) src_q.push_back($urandom());
      step($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
    end
    src_q.delete();
    repeat (6) step(1'b0, 1'b1);
    n_total++;
    if (exp_q.size() != 0) $display("FAIL random_lost: got %0d undelivered required 0", exp_q.size());
    else n_pass++;
    n_total++;
    if (n_xfer < 1000) $display("FAIL random_throughput: got %0d transfers required >= 1000", n_xfer);
    else n_pass++;
  endtask

  task automatic test_reset_in_flight();
    apply_reset();
    src_q = '{32'hD1, 32'hD2, 32'hD3, 32'hD4};
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    apply_reset();
    src_q = '{32'hA0, 32'hA1};
    repeat (6) step(1'b0, 1'b1);
    n_total++;
    if (n_xfer != 2 || exp_q.size() != 0)
      $display("FAIL flight_after_reset: got %0d transfers, %0d pending required 2, 0", n_xfer, exp_q.size());
    else n_pass++;
  endtask

`ifdef FIFO_STREAM_READER_COUNT_EN
  task automatic test_count();
    apply_reset();
    for (int i = 0; i < 7; i++) src_q.push_back(32'h100 + i);
    repeat (12) step(1'b0, 1'b1);
    n_total++;
    if (p_pop_count !== 32'd7) $display("FAIL count_seven: got %0d required 7", p_pop_count);
    else n_pass++;
    dut.pop_count_q = 32'hFFFF_FFFF;
    src_q.push_back(32'h200);
    repeat (5) step(1'b0, 1'b1);
    n_total++;
    if (p_pop_count !== 32'd0) $display("FAIL count_wrap: got %h required 0", p_pop_count);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_empty();
    test_random();
    test_reset_in_flight();
`ifdef FIFO_STREAM_READER_COUNT_EN
    test_count();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
